// File: rtl/arb8_pkg.sv
// Shared widths and FSM state type for the 8-way round-robin arbiter.
package arb8_pkg;
    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/enc83_onehot.sv
// Combinational 8:3 encoder: one-hot input to binary index; zero input gives index 0.
module enc83_onehot
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] i_onehot,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/arb8_rr.sv
// Round-robin arbiter for eight requesters with registered one-hot/encoded grant
// and a bounded hold time under contention.
module arb8_rr
    import arb8_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [N_REQ-1:0]  r_gnt;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic              r_gnt_valid;

    arb_state_t        w_state_nxt;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [N_REQ-1:0]  w_gnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;

    logic [IDX_W-1:0]  w_start;
    logic [N_REQ-1:0]  w_mask;
    logic [N_REQ-1:0]  w_masked;
    logic [N_REQ-1:0]  w_rot;
    logic [N_REQ-1:0]  w_rot_first;
    logic [IDX_W-1:0]  w_rot_idx;
    logic [IDX_W-1:0]  w_pick_idx;
    logic [N_REQ-1:0]  w_pick_oh;
    logic              w_hit;
    logic              w_owner_req;
    logic              w_others_req;

    // While granting, the search always starts just past the owner and skips it;
    // while idle it starts at the stored pointer over all requesters.
    assign w_start  = (r_state == GRANT) ? (r_gnt_idx + IDX_W'(1)) : r_ptr;
    assign w_mask   = (r_state == GRANT) ? ~(N_REQ'(1) << r_gnt_idx) : {N_REQ{1'b1}};
    assign w_masked = req & w_mask;
    assign w_hit    = |w_masked;

    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_rot[i] = w_masked[w_start + IDX_W'(i)];
        end
    end

    assign w_rot_first = w_rot & (~w_rot + N_REQ'(1));

    enc83_onehot u_enc (
        .i_onehot (w_rot_first),
        .o_idx    (w_rot_idx)
    );

    assign w_pick_idx   = w_rot_idx + w_start;
    assign w_pick_oh    = N_REQ'(1) << w_pick_idx;
    assign w_owner_req  = req[r_gnt_idx];
    assign w_others_req = w_hit;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_gnt_idx;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_pick_oh;
                    w_idx_nxt   = w_pick_idx;
                    w_hold_nxt  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    w_ptr_nxt = r_gnt_idx + IDX_W'(1);
                    if (w_hit) begin
                        w_gnt_nxt  = w_pick_oh;
                        w_idx_nxt  = w_pick_idx;
                        w_hold_nxt = HOLD_W'(1);
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_hold_nxt  = '0;
                    end
                end else if ((r_hold_cnt == HOLD_LIM) && w_others_req) begin
                    w_ptr_nxt  = r_gnt_idx + IDX_W'(1);
                    w_gnt_nxt  = w_pick_oh;
                    w_idx_nxt  = w_pick_idx;
                    w_hold_nxt = HOLD_W'(1);
                end else if (r_hold_cnt != HOLD_LIM) begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_gnt_valid <= |w_gnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_arb8_rr.sv
// Self-checking bench for arb8_rr: directed scenarios plus randomized requests
// against a behavioural round-robin model.
module tb_arb8_rr;
    localparam int HOLD_MAX = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_checks;
    int n_fail;

    // Reference model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;

    arb8_rr #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(int start, logic [7:0] r, int excl);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (start + k) % 8;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt();
        logic [7:0] one;
        one = 8'd1;
        return m_busy ? (one << m_owner) : 8'd0;
    endfunction

    function automatic logic [2:0] exp_idx();
        return m_busy ? 3'(m_owner) : 3'd0;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        int p;
        bit others;
        if (!m_busy) begin
            p = pick(m_ptr, r, -1);
            if (p >= 0) begin
                m_busy = 1'b1; m_owner = p; m_hold = 1;
            end
        end else if (!r[m_owner]) begin
            m_ptr = (m_owner + 1) % 8;
            p = pick(m_ptr, r, m_owner);
            if (p >= 0) begin
                m_owner = p; m_hold = 1;
            end else begin
                m_busy = 1'b0; m_owner = 0; m_hold = 0;
            end
        end else begin
            others = (pick(0, r, m_owner) >= 0);
            if (m_hold == HOLD_MAX && others) begin
                m_ptr = (m_owner + 1) % 8;
                m_owner = pick(m_ptr, r, m_owner);
                m_hold = 1;
            end else if (m_hold < HOLD_MAX) begin
                m_hold++;
            end
        end
    endtask

    task automatic tick(input logic [7:0] r);
        req = r;
        model_edge(r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick(8'h00);
            n_checks++;
            if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset c%0d: gnt=%h idx=%0d vld=%b expected 00/0/0", c, gnt, gnt_idx, gnt_valid);
            end
        end
    endtask

    task automatic test_release_chain();
        tick(8'h84);
        n_checks++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: gnt=%h idx=%0d vld=%b expected 04/2/1", gnt, gnt_idx, gnt_valid);
        end
        tick(8'h80);
        n_checks++;
        if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
            n_fail++;
            $display("FAIL release_to_7: gnt=%h idx=%0d expected 80/7", gnt, gnt_idx);
        end
        tick(8'h00);
        n_checks++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_to_idle: gnt=%h idx=%0d vld=%b expected 00/0/0", gnt, gnt_idx, gnt_valid);
        end
        tick(8'h01);
        n_checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ptr_wrap: gnt=%h idx=%0d vld=%b expected 01/0/1", gnt, gnt_idx, gnt_valid);
        end
        tick(8'h00);
    endtask

    task automatic test_rotation();
        logic [7:0] one;
        int e;
        one = 8'd1;
        do_reset();
        for (int k = 0; k < 33; k++) begin
            tick(8'hFF);
            e = (k / HOLD_MAX) % 8;
            n_checks++;
            if (gnt_idx !== 3'(e) || gnt !== (one << e)) begin
                n_fail++;
                $display("FAIL rotation k%0d: gnt=%h idx=%0d expected idx %0d", k, gnt, gnt_idx, e);
            end
        end
    endtask

    task automatic test_uncontested();
        for (int c = 0; c < 12; c++) begin
            tick(8'h20);
            n_checks++;
            if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
                n_fail++;
                $display("FAIL uncontested c%0d: gnt=%h idx=%0d expected 20/5", c, gnt, gnt_idx);
            end
        end
        // A saturated counter forces rotation as soon as a competitor appears.
        tick(8'h21);
        n_checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL hold_saturate: gnt=%h idx=%0d expected 01/0", gnt, gnt_idx);
        end
    endtask

    task automatic test_back_to_back();
        tick(8'h08);
        tick(8'h08);
        n_checks++;
        if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL handoff_setup: gnt=%h idx=%0d expected 08/3", gnt, gnt_idx);
        end
        tick(8'h02);
        n_checks++;
        if (gnt !== 8'h02 || gnt_idx !== 3'd1 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL handoff_no_bubble: gnt=%h idx=%0d vld=%b expected 02/1/1", gnt, gnt_idx, gnt_valid);
        end
    endtask

    task automatic test_async_reset();
        tick(8'h10);
        n_checks++;
        if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin
            n_fail++;
            $display("FAIL async_setup: gnt=%h idx=%0d expected 10/4", gnt, gnt_idx);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_drop: gnt=%h idx=%0d vld=%b expected 00/0/0", gnt, gnt_idx, gnt_valid);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(8'h81);
        n_checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: gnt=%h idx=%0d vld=%b expected 01/0/1", gnt, gnt_idx, gnt_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        int sel;
        for (int c = 0; c < 400; c++) begin
            r   = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 3) r = r & 8'($urandom) & 8'($urandom);
            else if (sel == 3) r = 8'h00;
            else if (sel == 4) r = req;
            tick(r);
            n_checks++;
            if (gnt !== exp_gnt() || gnt_idx !== exp_idx() || gnt_valid !== m_busy) begin
                n_fail++;
                $display("FAIL random c%0d req=%h: gnt=%h idx=%0d vld=%b expected %h/%0d/%b",
                         c, r, gnt, gnt_idx, gnt_valid, exp_gnt(), exp_idx(), m_busy);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = 8'h00;
        model_reset();
        test_reset();
        test_release_chain();
        test_rotation();
        test_uncontested();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb8_rr.md
# arb8_rr

Round-robin arbiter sharing one resource among eight requesters, built around the team's 8:3 encoder. It produces a registered one-hot grant, the 3-bit encoded grant index and a valid flag. It sits in front of any shared datapath whose select lines take the encoded index. Grants are held while the owner keeps requesting, but ownership is forced to rotate after a bounded hold time when other requesters are waiting.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive cycles one owner keeps the grant while others are requesting. Legal range 1..15.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `req`  input  8  request vector; bit i high means requester i wants the resource.
- `gnt`  output  8  one-hot grant, registered; all zero when idle.
- `gnt_idx`  output  3  encoded index of the set bit in `gnt`, registered; holds 0 when idle.
- `gnt_valid`  output  1  high when `gnt` is non-zero, registered.

## Operation
- State: FSM {IDLE, GRANT}, 3-bit pointer `ptr`, 4-bit `hold_cnt`, owner index.
- Reset values, applied immediately on `rst_n` low without waiting for a clock:
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0
  - `ptr`=0, `hold_cnt`=0, state IDLE
- Rotating search `pick(start, mask)`: the first set bit of `req & mask`, scanning start, start+1, … mod 8. The index is produced by the 8:3 encoder sub-module applied to the rotated one-hot result.
- IDLE:
  - `req`==0: stay idle.
  - Otherwise: grant `pick(ptr, 8'hFF)`, set `hold_cnt`=1, go to GRANT.
- GRANT, owner o:
  - Owner releases (`req[o]`=0): set `ptr`=o+1 mod 8. Search `pick(o+1, ~(1<<o))`.
    - Hit: grant it on the same edge (no idle bubble) and set `hold_cnt`=1.
    - No hit: go to IDLE with all grant outputs 0.
  - Owner still requesting, `hold_cnt`==HOLD_MAX, and other bits of `req` set: forced rotation. Grant `pick(o+1, ~(1<<o))`, set `ptr`=o+1, `hold_cnt`=1.
  - Owner still requesting otherwise: keep the grant. `hold_cnt` increments, saturating at HOLD_MAX.
- `ptr` wraps 7→0 by plain 3-bit modular arithmetic.
- `gnt` is always zero or one-hot. `gnt_idx` always equals the encoding of `gnt`. `gnt_valid` = |`gnt`.

## Timing
- `req` is sampled on the rising edge. The first grant is visible in the cycle after the edge that samples the request (latency 1).
- Release to next grant: 1 edge. The new owner is visible in the cycle after `req[o]` is sampled low.
- A single uncontested owner holds the grant indefinitely.
- With contention, an owner holds the grant for at most HOLD_MAX cycles.
- `req` changes between edges have no effect until the next edge.
- Simultaneous owner release and new request on one edge: the new request competes normally in the search from o+1.
- Reset asserted mid-grant: outputs drop to 0 asynchronously. After `rst_n` deasserts, the first sampling edge behaves as IDLE with `ptr`=0.

## Structure
- Package `arb8_pkg`:
  - `N_REQ`=8, `IDX_W`=3, `HOLD_W`=4
  - state enum `arb_state_t` {IDLE, GRANT}
- Sub-module `enc83_onehot`: combinational 8:3 encoder, one-hot in, index out, same mapping as the existing encoder.
- Top module owns the rotation (barrel rotate by `ptr`), the FSM and all registers.
- Target size: 150–250 lines of RTL.

## Test plan
- Reset with `req`=0 → `gnt`=8'h00, `gnt_idx`=0, `gnt_valid`=0 for 5 cycles.
- From reset, `req`=8'h84:
  - cycle+1: `gnt`=8'h04, `gnt_idx`=2.
  - Drop bit 2 → next cycle `gnt`=8'h80, `gnt_idx`=7.
  - Drop bit 7 → `gnt`=0, `gnt_valid`=0.
  - Then `req`=8'h01 → grant index 0 (`ptr` wrapped to 0).
- `HOLD_MAX`=4, `req`=8'hFF held → `gnt_idx` sequence 0,1,2,…,7,0, each index held exactly 4 cycles.
- `req`=8'h20 held 12 cycles → `gnt`=8'h20 throughout, no forced rotation, `hold_cnt` saturates at 4.
- Owner 3 releases on the same edge requester 1 first requests (`req`=8'h02 after 8'h08) → next cycle `gnt_idx`=1, no idle cycle.
- `rst_n` pulsed low mid-cycle while `gnt`=8'h10 → outputs 0 before the next edge. After release, `req`=8'h81 → `gnt_idx`=0.
